uart_tx_queue: RTL and testbench

//  Byte queue and dispatcher sitting directly upstream of the UART transmitter.

---
 rtl/uart_tx_queue_pkg.sv | 21 ++
 rtl/uart_tx_queue_if.sv | 34 +++
 rtl/uart_byte_fifo.sv | 78 +++++++
 rtl/uart_tx_queue.sv | 112 +++++++++++
 tb/tb_uart_tx_queue.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_queue_pkg.sv
// Shared types and sizing helpers for the UART transmit byte queue.
package uart_tx_queue_pkg;

  // Dispatcher states: either free to issue, or waiting on the transmitter.
  typedef enum logic {
    S_IDLE      = 1'b0,
    S_WAIT_DONE = 1'b1
  } tx_state_e;

  localparam int unsigned ByteW              = 8;
  localparam int unsigned DefaultAddrW       = 4;
  localparam int unsigned DefaultTimeoutClks = 20000;

  // Watchdog width: must hold every value from 0 up to and including clks.
  function automatic int unsigned timeout_cnt_w(input int unsigned clks);
    return $clog2(clks + 1);
  endfunction

  localparam int unsigned DefaultTimeoutW = timeout_cnt_w(DefaultTimeoutClks);

endpackage

// File: rtl/uart_tx_queue_if.sv
// Producer-side and transmitter-side signals of the UART transmit byte queue.
// The master modport is the environment (producers plus the transmitter);
// the slave modport is the queue itself.
interface uart_tx_queue_if #(
  parameter int unsigned ADDR_W = 4
) ();
  import uart_tx_queue_pkg::*;

  // Producer push side
  logic             wr_en;
  logic [ByteW-1:0] wr_byte;
  logic             full;
  logic             empty;
  logic [ADDR_W:0]  count;
  logic             overflow;
  logic             timeout;

  // Transmitter handshake side
  logic             tx_dv;
  logic [ByteW-1:0] tx_byte;
  logic             tx_active;
  logic             tx_done;

  modport master (
    output wr_en, wr_byte, tx_active, tx_done,
    input  full, empty, count, overflow, timeout, tx_dv, tx_byte
  );

  modport slave (
    input  wr_en, wr_byte, tx_active, tx_done,
    output full, empty, count, overflow, timeout, tx_dv, tx_byte
  );

endinterface

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO, depth 2**ADDR_W. Registered pointers and count;
// the head byte is read combinationally from the storage array.
module uart_byte_fifo
  import uart_tx_queue_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Push,
  input  logic [ByteW-1:0] i_Data,
  input  logic             i_Pop,
  output logic [ByteW-1:0] o_Head,
  output logic             o_Full,
  output logic             o_Empty,
  output logic [ADDR_W:0]  o_Count,
  output logic             o_Drop
);

  localparam int unsigned      Depth    = 1 << ADDR_W;
  localparam logic [ADDR_W:0]  DepthCnt = {1'b1, {ADDR_W{1'b0}}};

  logic [ByteW-1:0]  mem_q [Depth];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              accept;
  logic              do_pop;

  assign o_Full  = (count_q == DepthCnt);
  assign o_Empty = (count_q == '0);
  assign o_Count = count_q;
  assign o_Head  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a push on a full FIFO needs.
  assign do_pop = i_Pop && !o_Empty;
  assign accept = i_Push && (!o_Full || do_pop);
  assign o_Drop = i_Push && !accept;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    case ({accept, do_pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers, cleared by synchronous reset.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care after reset since the pointers restart.
  always_ff @(posedge i_Clock) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= i_Data;
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and dispatcher in front of the UART transmitter. Bytes pushed
// by producers are buffered, then handed to the transmitter one at a time.
// A watchdog releases the dispatcher if the transmitter never reports done.
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int unsigned ADDR_W       = DefaultAddrW,
  parameter int unsigned TIMEOUT_CLKS = DefaultTimeoutClks
) (
  input logic           i_Clock,
  input logic           i_Reset,
  uart_tx_queue_if.slave bus
);

  localparam int unsigned    WdW    = timeout_cnt_w(TIMEOUT_CLKS);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CLKS - 1);

  tx_state_e        state_q, state_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic             tx_dv_q, tx_dv_d;
  logic [ByteW-1:0] tx_byte_q, tx_byte_d;
  logic             overflow_q, overflow_d;
  logic             timeout_q, timeout_d;

  logic             pop;
  logic [ByteW-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_drop;
  logic [ADDR_W:0]  fifo_count;

  uart_byte_fifo #(
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Push  (bus.wr_en),
    .i_Data  (bus.wr_byte),
    .i_Pop   (pop),
    .o_Head  (fifo_head),
    .o_Full  (fifo_full),
    .o_Empty (fifo_empty),
    .o_Count (fifo_count),
    .o_Drop  (fifo_drop)
  );

  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.count    = fifo_count;
  assign bus.overflow = overflow_q;
  assign bus.timeout  = timeout_q;
  assign bus.tx_dv    = tx_dv_q;
  assign bus.tx_byte  = tx_byte_q;

  // Dispatcher next-state, watchdog, and registered-output next values.
  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    tx_dv_d    = 1'b0;
    tx_byte_d  = tx_byte_q;
    overflow_d = overflow_q | fifo_drop;
    timeout_d  = timeout_q;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A lingering done (e.g. left over across a reset) also blocks issue,
        // so the transmitter is never handed a byte before it is truly idle.
        if (!fifo_empty && !bus.tx_active && !bus.tx_done) begin
          pop       = 1'b1;
          tx_byte_d = fifo_head;
          tx_dv_d   = 1'b1;
          wd_d      = '0;
          state_d   = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        wd_d = wd_q + WdW'(1);
        if (bus.tx_done) begin
          state_d = S_IDLE;
        end else if (wd_q == WdLast) begin
          // Give up on this byte; it is treated as sent.
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, watchdog, sticky flags and transmitter-facing output registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      wd_q       <= '0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: transmitter model, queue-level reference model,
// scoreboard of accepted bytes, directed scenarios and a randomized phase.
module tb_uart_tx_queue;
  import uart_tx_queue_pkg::*;

  localparam int unsigned ADDR_W       = 2;
  localparam int unsigned DEPTH        = 4;
  localparam int unsigned TIMEOUT_CLKS = 50;
  localparam int unsigned CLKS_PER_BIT = 4;
  localparam int unsigned FRAME        = 10 * CLKS_PER_BIT;
  localparam int unsigned STALL_LEN    = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_queue_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_queue #(
    .ADDR_W       (ADDR_W),
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- transmitter model (never reset) ----------------
  logic tx_busy   = 1'b0;
  logic tx_act_q  = 1'b0;
  logic tx_done_q = 1'b0;
  logic tx_quiet  = 1'b0;
  int   tx_cnt    = 0;
  int   tx_len    = 0;
  bit   tx_stall  = 1'b0;
  bit   hold_active = 1'b0;

  assign bus.tx_active = tx_act_q | hold_active;
  assign bus.tx_done   = tx_done_q;

  always @(posedge clk) begin
    if (!tx_busy) begin
      tx_done_q <= 1'b0;
      if (bus.tx_dv === 1'b1) begin
        tx_busy  <= 1'b1;
        tx_act_q <= 1'b1;
        tx_cnt   <= 0;
        tx_len   <= tx_stall ? STALL_LEN : FRAME;
        tx_quiet <= tx_stall;
      end
    end else begin
      tx_cnt <= tx_cnt + 1;
      if (tx_cnt == tx_len - 1) begin
        tx_busy   <= 1'b0;
        tx_act_q  <= 1'b0;
        tx_done_q <= !tx_quiet;
      end
    end
  end

  // ---------------- queue-level reference model ----------------
  logic [7:0] mq[$];     // bytes the queue holds
  logic [7:0] exp_q[$];  // scoreboard: accepted bytes awaiting their DV strobe
  bit         m_busy = 1'b0;
  bit         m_ovf  = 1'b0;
  bit         m_to   = 1'b0;
  bit         m_dv   = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         m_wait = 0;

  always @(posedge clk) begin
    bit m_pop;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_busy = 1'b0; m_ovf = 1'b0; m_to = 1'b0; m_dv = 1'b0; m_byte = 8'h00; m_wait = 0;
    end else begin
      m_pop = !m_busy && (mq.size() != 0) && !bus.tx_active && !bus.tx_done;
      m_dv  = 1'b0;
      if (m_busy) begin
        m_wait++;
        if (bus.tx_done) m_busy = 1'b0;
        else if (m_wait == TIMEOUT_CLKS) begin
          m_busy = 1'b0;
          m_to   = 1'b1;
        end
      end
      if (m_pop) begin
        m_byte = mq.pop_front();
        m_dv   = 1'b1;
        m_busy = 1'b1;
        m_wait = 0;
      end
      if (bus.wr_en) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(bus.wr_byte);
          exp_q.push_back(bus.wr_byte);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [7:0] dv_log[$];
  int         dv_cyc_log[$];
  int         gap_log[$];
  int         cnt_log[$];
  bit         log_cnt       = 1'b0;
  int         prev_cnt      = 0;
  int         last_done_cyc = 0;
  int         to_rise_cyc   = 0;
  bit         prev_to       = 1'b0;
  logic       prev_tx_busy  = 1'b0;
  int         n_dv          = 0;

  always @(negedge clk) begin
    logic [7:0] e;
    if (mon_en) begin
      cyc++;
      if (bus.tx_done === 1'b1) last_done_cyc = cyc;
      chk("count", 32'(bus.count), mq.size());
      chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
      chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("timeout", 32'(bus.timeout), 32'(m_to));
      chk("tx_dv", 32'(bus.tx_dv), 32'(m_dv));
      chk("tx_byte", 32'(bus.tx_byte), 32'(m_byte));
      if (bus.tx_dv === 1'b1) begin
        n_dv++;
        chk("dv_while_tx_busy", 32'(prev_tx_busy), 0);
        dv_log.push_back(bus.tx_byte);
        dv_cyc_log.push_back(cyc);
        gap_log.push_back(cyc - last_done_cyc);
        chk("sb_byte_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_byte_order", 32'(bus.tx_byte), 32'(e));
        end
      end
      if (bus.timeout === 1'b1 && !prev_to) to_rise_cyc = cyc;
      prev_to      = (bus.timeout === 1'b1);
      prev_tx_busy = bus.tx_active | bus.tx_done;
      if (log_cnt && int'(bus.count) != prev_cnt) cnt_log.push_back(int'(bus.count));
      prev_cnt = int'(bus.count);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic we, input logic [7:0] b);
    bus.wr_en   = we;
    bus.wr_byte = b;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    bit reached = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (mq.size() == 0 && !m_busy && !tx_busy && !tx_done_q) begin
        reached = 1'b1;
        break;
      end
      step(1'b0, 8'h00);
    end
    chk({tag, "_idle_reached"}, 32'(reached), 1);
  endtask

  initial begin
    int base;
    int dvn;
    int exp_cnt[6];
    logic [7:0] t2_bytes[3];
    exp_cnt  = '{1, 2, 3, 2, 1, 0};
    t2_bytes = '{8'h11, 8'h22, 8'h33};
    bus.wr_en   = 1'b0;
    bus.wr_byte = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    rst = 1'b0;
    chk("reset_count", 32'(bus.count), 0);
    chk("reset_empty", 32'(bus.empty), 1);
    chk("reset_tx_byte", 32'(bus.tx_byte), 0);

    // 1: single-byte latency
    wait_idle("t1");
    base = dv_log.size();
    step(1'b1, 8'hA5);
    chk("t1_no_dv_yet", 32'(bus.tx_dv), 0);
    step(1'b0, 8'h00);
    chk("t1_dv", 32'(bus.tx_dv), 1);
    chk("t1_byte", 32'(bus.tx_byte), 32'hA5);
    chk("t1_empty", 32'(bus.empty), 1);
    step(1'b0, 8'h00);
    chk("t1_dv_one_cycle", 32'(bus.tx_dv), 0);

    // 2: three bytes queued behind the in-flight A5
    log_cnt = 1'b1;
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    step(1'b1, 8'h33);
    step(1'b0, 8'h00);
    wait_idle("t2");
    log_cnt = 1'b0;
    chk("t2_cnt_len", cnt_log.size(), 6);
    for (int i = 0; i < 6 && i < cnt_log.size(); i++) chk("t2_count_seq", cnt_log[i], exp_cnt[i]);
    chk("t2_dv_total", dv_log.size() - base, 4);
    for (int i = 0; i < 3 && base + 1 + i < dv_log.size(); i++) begin
      chk("t2_dv_order", 32'(dv_log[base + 1 + i]), 32'(t2_bytes[i]));
      chk("t2_done_to_dv_gap", gap_log[base + 1 + i], 2);
    end

    // 3: fill, overflow, push+pop on full
    wait_idle("t3");
    hold_active = 1'b1;
    step(1'b1, 8'hB0);
    step(1'b1, 8'hB1);
    step(1'b1, 8'hB2);
    step(1'b1, 8'hB3);
    chk("t3_no_ovf_at_full", 32'(bus.overflow), 0);
    chk("t3_full", 32'(bus.full), 1);
    step(1'b1, 8'hB4);
    chk("t3_count_4", 32'(bus.count), 4);
    chk("t3_overflow", 32'(bus.overflow), 1);
    hold_active = 1'b0;
    step(1'b1, 8'hB5);
    chk("t3_pushpop_count", 32'(bus.count), 4);
    chk("t3_pushpop_dv", 32'(bus.tx_dv), 1);
    chk("t3_pushpop_byte", 32'(bus.tx_byte), 32'hB0);
    step(1'b0, 8'h00);
    wait_idle("t3_drain");

    // 4: transmitter never signals done
    base = dv_log.size();
    tx_stall = 1'b1;
    step(1'b1, 8'h3C);
    step(1'b1, 8'h4D);
    step(1'b0, 8'h00);
    for (int i = 0; i < 200; i++) begin
      if (bus.timeout === 1'b1) break;
      step(1'b0, 8'h00);
    end
    tx_stall = 1'b0;
    step(1'b0, 8'h00);
    chk("t4_timeout_set", 32'(bus.timeout), 1);
    chk("t4_dv_seen", 32'(dv_log.size() > base), 1);
    if (dv_log.size() > base) chk("t4_timeout_latency", to_rise_cyc - dv_cyc_log[base], 50);
    wait_idle("t4");
    chk("t4_dv_total", dv_log.size() - base, 2);
    if (dv_log.size() > base + 1) begin
      chk("t4_first", 32'(dv_log[base]), 32'h3C);
      chk("t4_second", 32'(dv_log[base + 1]), 32'h4D);
    end

    // 5: reset mid-transmission with three bytes queued
    step(1'b1, 8'hC0);
    step(1'b1, 8'hC1);
    step(1'b1, 8'hC2);
    step(1'b1, 8'hC3);
    repeat (10) step(1'b0, 8'h00);
    chk("t5_queued_3", 32'(bus.count), 3);
    rst = 1'b1;
    step(1'b0, 8'h00);
    rst = 1'b0;
    chk("t5_count", 32'(bus.count), 0);
    chk("t5_dv", 32'(bus.tx_dv), 0);
    chk("t5_overflow", 32'(bus.overflow), 0);
    chk("t5_timeout", 32'(bus.timeout), 0);
    chk("t5_empty", 32'(bus.empty), 1);
    dvn = n_dv;
    step(1'b1, 8'hC9);
    repeat (5) step(1'b0, 8'h00);
    chk("t5_held_while_tx_busy", n_dv - dvn, 0);
    wait_idle("t5");
    chk("t5_after_release", n_dv - dvn, 1);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) tx_stall = 1'b1;
      else if ($urandom_range(0, 99) < 5) tx_stall = 1'b0;
      if ($urandom_range(0, 99) < 3) hold_active = ~hold_active;
      rst = ($urandom_range(0, 999) < 3);
      step($urandom_range(0, 99) < 30, 8'($urandom));
    end
    rst = 1'b0;
    tx_stall = 1'b0;
    hold_active = 1'b0;
    wait_idle("rand");
    step(1'b0, 8'h00);
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
